// File: rtl/watch_pkg.sv
// Shared constants for the watch display driver: segment patterns,
// alarm FSM encoding, digit indices and a counter-width helper.
package watch_pkg;

   // Segment patterns, active-high, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RINGING = 1'b1
   } alarm_state_e;

   localparam logic [1:0] DIG_MIN_ONES = 2'd0;
   localparam logic [1:0] DIG_MIN_TENS = 2'd1;
   localparam logic [1:0] DIG_HRS_ONES = 2'd2;
   localparam logic [1:0] DIG_HRS_TENS = 2'd3;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder; codes 10-15 are blank.
module bcd_to_7seg
   import watch_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/watch_display_driver.sv
// Multiplexed 4-digit seven-segment scanner with per-frame input snapshot,
// plus a cancellable, retriggerable alarm buzzer sequencer.
module watch_display_driver
   import watch_pkg::*;
#(
   parameter int unsigned CLKS_PER_SCAN = 4,
   parameter int unsigned BEEP_CLKS     = 2,
   parameter int unsigned ALARM_CLKS    = 60,
   parameter int unsigned ACTIVE_LOW    = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] disp_d3,
   input  logic [3:0] disp_d2,
   input  logic [3:0] disp_d1,
   input  logic [3:0] disp_d0,
   input  logic       alarm_on,
   input  logic       alarm_stop,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp,
   output logic       buzzer,
   output logic       alarm_active
);

   localparam int unsigned SCAN_W = cnt_width(CLKS_PER_SCAN);
   localparam int unsigned BEEP_W = cnt_width(BEEP_CLKS);
   localparam int unsigned RING_W = cnt_width(ALARM_CLKS);
   localparam logic        POL    = (ACTIVE_LOW != 0);

   logic [SCAN_W-1:0] presc_q, presc_d;
   logic [1:0]        idx_q, idx_d;
   logic [3:0][3:0]   snap_q, snap_d;
   logic              tick;
   logic [6:0]        seg_dec;
   logic [6:0]        seg_q, seg_d;
   logic [3:0]        an_q, an_d;
   logic              dp_q, dp_d;

   always_comb begin
      tick    = (presc_q == SCAN_W'(CLKS_PER_SCAN - 1));
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = tick ? idx_q + 2'd1 : idx_q;
      snap_d  = snap_q;
      if (tick && idx_q == DIG_HRS_TENS)
         snap_d = {disp_d3, disp_d2, disp_d1, disp_d0};
   end

   bcd_to_7seg u_dec (
      .bcd_i (snap_q[idx_q]),
      .seg_o (seg_dec)
   );

   always_comb begin
      seg_d = seg_dec;
      an_d  = 4'b0001 << idx_q;
      dp_d  = (idx_q == DIG_HRS_ONES);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         idx_q   <= '0;
         snap_q  <= '0;
         seg_q   <= '0;
         an_q    <= '0;
         dp_q    <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         dp_q    <= dp_d;
      end
   end

   // Polarity applied after the registers so reset also lands on the idle level
   assign seg = seg_q ^ {7{POL}};
   assign an  = an_q ^ {4{POL}};
   assign dp  = dp_q ^ POL;

   alarm_state_e      state_q, state_d;
   logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
   logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
   logic              buzzer_q, buzzer_d;
   logic              ring_last, beep_last;

   assign ring_last = (ring_cnt_q == RING_W'(ALARM_CLKS - 1));
   assign beep_last = (beep_cnt_q == BEEP_W'(BEEP_CLKS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ring_cnt_q <= '0;
         beep_cnt_q <= '0;
         buzzer_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
         beep_cnt_q <= beep_cnt_d;
         buzzer_q   <= buzzer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (alarm_on && !alarm_stop) state_d = ST_RINGING;
         ST_RINGING: begin
            if (alarm_stop)                  state_d = ST_IDLE;
            else if (!alarm_on && ring_last) state_d = ST_IDLE;
         end
         default:    state_d = ST_IDLE;
      endcase
   end

   // Retrigger only rewinds the ring timer; the beep phase keeps running
   always_comb begin
      ring_cnt_d = '0;
      beep_cnt_d = '0;
      buzzer_d   = 1'b0;
      if (state_d == ST_RINGING) begin
         if (state_q == ST_IDLE) begin
            buzzer_d = 1'b1;
         end else begin
            ring_cnt_d = alarm_on ? '0 : ring_cnt_q + 1'b1;
            beep_cnt_d = beep_last ? '0 : beep_cnt_q + 1'b1;
            buzzer_d   = beep_last ? ~buzzer_q : buzzer_q;
         end
      end
      alarm_active = (state_q == ST_RINGING);
   end

   assign buzzer = buzzer_q;

endmodule

// File: tb/tb_watch_display_driver.sv
// Directed self-checking bench: scan timing, snapshot framing, decode,
// alarm ring/stop/retrigger/reset, and the active-low variant.
module tb_watch_display_driver;

   logic       clk, rst;
   logic [3:0] d3, d2, d1, d0;
   logic       alarm_on, alarm_stop;
   logic [6:0] seg, seg_n;
   logic [3:0] an, an_n;
   logic       dp, dp_n, buzzer, buzzer_n, active, active_n;

   int vectors    = 0;
   int miscompares = 0;

   watch_display_driver u_dut (
      .clk(clk), .rst(rst),
      .disp_d3(d3), .disp_d2(d2), .disp_d1(d1), .disp_d0(d0),
      .alarm_on(alarm_on), .alarm_stop(alarm_stop),
      .seg(seg), .an(an), .dp(dp), .buzzer(buzzer), .alarm_active(active)
   );

   watch_display_driver #(.ACTIVE_LOW(1)) u_inv (
      .clk(clk), .rst(rst),
      .disp_d3(d3), .disp_d2(d2), .disp_d1(d1), .disp_d0(d0),
      .alarm_on(alarm_on), .alarm_stop(alarm_stop),
      .seg(seg_n), .an(an_n), .dp(dp_n), .buzzer(buzzer_n), .alarm_active(active_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_on();
      alarm_on = 1'b1;
      step(1);
      alarm_on = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; d3 = 0; d2 = 0; d1 = 0; d0 = 0;
      alarm_on = 1'b0; alarm_stop = 1'b0;
      #2;
      chk("rst_seg", 8'(seg), 8'h00);
      chk("rst_an", 8'(an), 8'h0);
      chk("rst_dp", 8'(dp), 8'h0);
      chk("rst_buz", 8'(buzzer), 8'h0);
      chk("rst_act", 8'(active), 8'h0);
      chk("rst_seg_n", 8'(seg_n), 8'h7f);
      chk("rst_an_n", 8'(an_n), 8'hf);
      chk("rst_dp_n", 8'(dp_n), 8'h1);
      #10 rst = 1'b0;

      // k = edges since release
      step(1);                                  // k=1
      chk("k1_an", 8'(an), 8'h1);
      chk("k1_seg", 8'(seg), 8'h3f);
      d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
      step(3);                                  // k=4
      chk("k4_an", 8'(an), 8'h1);
      step(1);                                  // k=5
      chk("k5_an", 8'(an), 8'h2);
      chk("k5_seg_old", 8'(seg), 8'h3f);
      step(4);                                  // k=9
      chk("k9_an", 8'(an), 8'h4);
      chk("k9_dp", 8'(dp), 8'h1);
      chk("k9_seg_old", 8'(seg), 8'h3f);
      step(7);                                  // k=16
      chk("k16_an", 8'(an), 8'h8);
      chk("k16_dp", 8'(dp), 8'h0);
      chk("k16_seg_old", 8'(seg), 8'h3f);
      step(1);                                  // k=17, frame 1
      chk("f1d0_an", 8'(an), 8'h1);
      chk("f1d0_seg", 8'(seg), 8'h66);
      step(4);
      chk("f1d1_an", 8'(an), 8'h2);
      chk("f1d1_seg", 8'(seg), 8'h4f);
      step(4);                                  // k=25
      chk("f1d2_an", 8'(an), 8'h4);
      chk("f1d2_seg", 8'(seg), 8'h5b);
      chk("f1d2_dp", 8'(dp), 8'h1);
      chk("f1d2_seg_n", 8'(seg_n), 8'h24);
      chk("f1d2_an_n", 8'(an_n), 8'hb);
      chk("f1d2_dp_n", 8'(dp_n), 8'h0);
      step(4);
      chk("f1d3_an", 8'(an), 8'h8);
      chk("f1d3_seg", 8'(seg), 8'h06);
      step(4);                                  // k=33
      chk("f2d0_an", 8'(an), 8'h1);
      step(1);                                  // k=34
      d1 = 4'd7; d2 = 4'd12;
      step(3);                                  // k=37
      chk("f2d1_seg_old", 8'(seg), 8'h4f);
      step(4);                                  // k=41
      chk("f2d2_seg_old", 8'(seg), 8'h5b);
      step(8);                                  // k=49
      chk("f3d0_seg", 8'(seg), 8'h66);
      step(4);
      chk("f3d1_seg", 8'(seg), 8'h07);
      step(4);                                  // k=57
      chk("f3d2_an", 8'(an), 8'h4);
      chk("f3d2_blank", 8'(seg), 8'h00);
      chk("f3d2_dp", 8'(dp), 8'h1);
      chk("f3d2_blank_n", 8'(seg_n), 8'h7f);

      // m = edges since alarm_on was sampled
      pulse_on();                               // m=0
      chk("ring_m0_act", 8'(active), 8'h1);
      chk("ring_m0_buz", 8'(buzzer), 8'h1);
      step(1);
      chk("ring_m1_buz", 8'(buzzer), 8'h1);
      step(1);
      chk("ring_m2_buz", 8'(buzzer), 8'h0);
      step(1);
      chk("ring_m3_buz", 8'(buzzer), 8'h0);
      step(1);
      chk("ring_m4_buz", 8'(buzzer), 8'h1);
      chk("ring_m4_buz_n", 8'(buzzer_n), 8'h1);
      step(55);                                 // m=59
      chk("ring_m59_act", 8'(active), 8'h1);
      chk("ring_m59_buz", 8'(buzzer), 8'h0);
      step(1);                                  // m=60
      chk("ring_m60_act", 8'(active), 8'h0);
      chk("ring_m60_buz", 8'(buzzer), 8'h0);
      step(3);

      pulse_on();
      step(9);                                  // m=9
      chk("stop_m9_act", 8'(active), 8'h1);
      alarm_stop = 1'b1;
      step(1);                                  // m=10
      alarm_stop = 1'b0;
      chk("stop_act", 8'(active), 8'h0);
      chk("stop_buz", 8'(buzzer), 8'h0);
      step(2);

      alarm_on = 1'b1; alarm_stop = 1'b1;
      step(1);
      alarm_on = 1'b0; alarm_stop = 1'b0;
      chk("coinc_act", 8'(active), 8'h0);
      step(1);
      chk("coinc_act2", 8'(active), 8'h0);
      chk("coinc_buz", 8'(buzzer), 8'h0);

      pulse_on();
      step(39);                                 // m=39
      pulse_on();                               // m=40 retrigger
      chk("retrig_m40_buz", 8'(buzzer), 8'h1);
      step(2);                                  // m=42
      chk("retrig_m42_buz", 8'(buzzer), 8'h0);
      step(18);                                 // m=60
      chk("retrig_m60_act", 8'(active), 8'h1);
      step(39);                                 // m=99
      chk("retrig_m99_act", 8'(active), 8'h1);
      step(1);                                  // m=100
      chk("retrig_m100_act", 8'(active), 8'h0);
      step(2);

      pulse_on();
      step(20);
      #1 rst = 1'b1;
      #1;
      chk("arst_act", 8'(active), 8'h0);
      chk("arst_buz", 8'(buzzer), 8'h0);
      chk("arst_an", 8'(an), 8'h0);
      chk("arst_seg", 8'(seg), 8'h00);
      chk("arst_an_n", 8'(an_n), 8'hf);
      @(negedge clk);
      rst = 1'b0;
      step(1);
      chk("rel_an", 8'(an), 8'h1);
      chk("rel_seg", 8'(seg), 8'h3f);
      chk("rel_act", 8'(active), 8'h0);
      chk("rel_an_n", 8'(an_n), 8'he);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
